// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared constants and types for the block-transfer sequencer
//               (register-file geometry, PC index, sequencer state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    // ARMv7 register file: 16 architectural registers, R15 is the PC
    localparam int         NUM_REGS = 16;
    localparam logic [3:0] REG_PC   = 4'd15;

    // Sequencer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } xfer_state_e;

endpackage
`default_nettype wire

// File: rtl/lowest_set_bit.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_bit
// Description : Combinational 16->4 priority encoder returning the index of
//               the lowest set bit, plus a flag that any bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_bit
    import arm_pkg::*;
(
    input  logic [NUM_REGS-1:0] vec_i,
    output logic [3:0]          idx_o,
    output logic                valid_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx_o   = 4'd0;
        valid_o = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/block_transfer_seq.sv
`default_nettype none
// ============================================================================
// Module      : block_transfer_seq
// Description : LDM/STM sequencer. Walks a 16-bit register list in ascending
//               order, issues one memory access per register, drives the
//               register-file ports and optionally writes back the base.
// Revision    : 1.0 - initial release
// ============================================================================
module block_transfer_seq
    import arm_pkg::*;
(
    input  logic        CP,
    input  logic        reset,
    input  logic        start,
    input  logic        isLoad,
    input  logic [15:0] regList,
    input  logic [3:0]  baseReg,
    input  logic [31:0] baseAddr,
    input  logic        P,
    input  logic        U,
    input  logic        W,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    input  logic        memReady,
    input  logic [31:0] memRData,
    output logic [31:0] memWData,
    output logic [3:0]  rfAddrA,
    input  logic [31:0] rfDataA,
    output logic [3:0]  rfAddrW,
    output logic [31:0] rfDataW,
    output logic        rfRegW
);

    xfer_state_e state_q, state_d;

    logic [15:0] list_q;
    logic        is_load_q;
    logic [3:0]  base_reg_q;
    logic [31:0] base_addr_q;
    logic        up_q;
    logic        wb_q;
    logic        err_q;
    logic [4:0]  cnt_q;
    logic [31:0] mem_addr_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic [4:0]  w_pop;
    logic [31:0] w_req_off;
    logic [31:0] w_low_addr;
    logic        w_wb_apply;
    logic        w_accept;
    logic [3:0]  w_cur_idx;
    logic        w_cur_valid;
    logic [15:0] w_list_next;
    logic        w_last;
    logic        w_step;
    logic [31:0] w_lat_off;

    lowest_set_bit u_lsb (
        .vec_i   (list_q),
        .idx_o   (w_cur_idx),
        .valid_o (w_cur_valid)
    );

    // Request decode: register count, lowest address and writeback decision
    always_comb begin
        w_pop = 5'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pop = w_pop + 5'(regList[i]);
        end
        w_req_off = {25'd0, w_pop, 2'b00};
        case ({U, P})
            2'b10:   w_low_addr = baseAddr;
            2'b11:   w_low_addr = baseAddr + 32'd4;
            2'b00:   w_low_addr = baseAddr - w_req_off + 32'd4;
            default: w_low_addr = baseAddr - w_req_off;
        endcase
        // A load that includes the base register keeps the loaded value
        w_wb_apply  = W & ~(isLoad & regList[baseReg]);
        w_accept    = (state_q == ST_IDLE) & start;
        w_list_next = list_q & ~(16'd1 << w_cur_idx);
        w_last      = (w_list_next == 16'd0);
        w_step      = (state_q == ST_XFER) & memReady;
        w_lat_off   = {25'd0, cnt_q, 2'b00};
    end

    // State register
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (w_pop == 5'd0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (memReady && w_last) begin
                    state_d = wb_q ? ST_WB : ST_DONE;
                end
            end
            ST_WB:   state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch and registered memory-side address/strobes
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            list_q      <= 16'd0;
            is_load_q   <= 1'b0;
            base_reg_q  <= 4'd0;
            base_addr_q <= 32'd0;
            up_q        <= 1'b0;
            wb_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 5'd0;
            mem_addr_q  <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (w_accept) begin
            list_q      <= regList;
            is_load_q   <= isLoad;
            base_reg_q  <= baseReg;
            base_addr_q <= baseAddr;
            up_q        <= U;
            wb_q        <= w_wb_apply;
            err_q       <= (w_pop == 5'd0);
            cnt_q       <= w_pop;
            mem_addr_q  <= w_low_addr;
            mem_read_q  <= isLoad & (w_pop != 5'd0);
            mem_write_q <= ~isLoad & (w_pop != 5'd0);
        end else if (w_step) begin
            list_q     <= w_list_next;
            mem_addr_q <= mem_addr_q + 32'd4;
            if (w_last) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    // Output decode: status, store-data path, register-file ports
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        err      = (state_q == ST_DONE) & err_q;
        memAddr  = mem_addr_q;
        memRead  = mem_read_q;
        memWrite = mem_write_q;
        memWData = 32'd0;
        rfAddrA  = 4'd0;
        rfAddrW  = 4'd0;
        rfDataW  = 32'd0;
        rfRegW   = 1'b0;
        case (state_q)
            ST_XFER: begin
                if (w_cur_valid) begin
                    if (is_load_q) begin
                        rfAddrW = w_cur_idx;
                        rfDataW = memRData;
                        rfRegW  = memReady;
                    end else begin
                        rfAddrA  = w_cur_idx;
                        memWData = rfDataA;
                    end
                end
            end
            ST_WB: begin
                rfAddrW = base_reg_q;
                rfDataW = up_q ? (base_addr_q + w_lat_off) : (base_addr_q - w_lat_off);
                rfRegW  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_block_transfer_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_transfer_seq
// Description : Directed self-checking bench for block_transfer_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_transfer_seq;

    logic        CP = 1'b0;
    logic        reset;
    logic        start;
    logic        isLoad;
    logic [15:0] regList;
    logic [3:0]  baseReg;
    logic [31:0] baseAddr;
    logic        P, U, W;
    logic        busy, done, err;
    logic [31:0] memAddr;
    logic        memRead, memWrite;
    logic        memReady;
    logic [31:0] memRData;
    logic [31:0] memWData;
    logic [3:0]  rfAddrA;
    logic [31:0] rfDataA;
    logic [3:0]  rfAddrW;
    logic [31:0] rfDataW;
    logic        rfRegW;

    int n_total = 0;
    int n_bad   = 0;

    block_transfer_seq dut (
        .CP       (CP),
        .reset    (reset),
        .start    (start),
        .isLoad   (isLoad),
        .regList  (regList),
        .baseReg  (baseReg),
        .baseAddr (baseAddr),
        .P        (P),
        .U        (U),
        .W        (W),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .memAddr  (memAddr),
        .memRead  (memRead),
        .memWrite (memWrite),
        .memReady (memReady),
        .memRData (memRData),
        .memWData (memWData),
        .rfAddrA  (rfAddrA),
        .rfDataA  (rfDataA),
        .rfAddrW  (rfAddrW),
        .rfDataW  (rfDataW),
        .rfRegW   (rfRegW)
    );

    always #5 CP = ~CP;

    // Memory returns a tagged copy of the address; register file returns a tagged index
    always_comb memRData = memAddr ^ 32'hA5A5_0000;
    always_comb rfDataA  = 32'hCAFE_0000 | {28'd0, rfAddrA};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic issue(input logic ld, input logic [15:0] lst, input logic [3:0] rn,
                         input logic [31:0] ba, input logic p, input logic u, input logic w);
        start = 1'b1; isLoad = ld; regList = lst; baseReg = rn; baseAddr = ba;
        P = p; U = u; W = w;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; isLoad = 1'b0; regList = 16'd0; baseReg = 4'd0;
        baseAddr = 32'd0; P = 1'b0; U = 1'b0; W = 1'b0; memReady = 1'b1;
        tick();
        tick();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_memaddr", memAddr, 32'd0);
        check_val("rst_strobes", {29'd0, memRead, memWrite, rfRegW}, 32'd0);
        reset = 1'b1;
        tick();

        // STM R0,R2 from 0x100 increment-after with writeback to R13
        issue(1'b0, 16'h0005, 4'd13, 32'h100, 1'b0, 1'b1, 1'b1);
        tick(); start = 1'b0;                      // t+1
        check_val("stm1_busy", {31'd0, busy}, 32'd1);
        check_val("stm1_a0", memAddr, 32'h100);
        check_val("stm1_wr0", {30'd0, memWrite, memRead}, 32'd2);
        check_val("stm1_ra0", {28'd0, rfAddrA}, 32'd0);
        check_val("stm1_wd0", memWData, 32'hCAFE_0000);
        tick();                                    // t+2
        check_val("stm1_a1", memAddr, 32'h104);
        check_val("stm1_ra1", {28'd0, rfAddrA}, 32'd2);
        check_val("stm1_wd1", memWData, 32'hCAFE_0002);
        tick();                                    // t+3 writeback
        check_val("stm1_wb_we", {31'd0, rfRegW}, 32'd1);
        check_val("stm1_wb_addr", {28'd0, rfAddrW}, 32'd13);
        check_val("stm1_wb_data", rfDataW, 32'h108);
        check_val("stm1_wb_mw", {31'd0, memWrite}, 32'd0);
        tick();                                    // t+4
        check_val("stm1_done", {30'd0, done, err}, 32'd2);
        tick();
        check_val("stm1_idle", {31'd0, busy}, 32'd0);

        // LDM R0,R1,R15 decrement-before, base in list so no writeback
        issue(1'b1, 16'h8003, 4'd1, 32'h200, 1'b1, 1'b0, 1'b1);
        tick(); start = 1'b0;                      // t+1
        check_val("ldm_a0", memAddr, 32'h1F4);
        check_val("ldm_rd0", {30'd0, memRead, memWrite}, 32'd2);
        check_val("ldm_w0", {27'd0, rfRegW, rfAddrW}, 32'h10);
        check_val("ldm_d0", rfDataW, 32'hA5A5_01F4);
        tick();                                    // t+2
        check_val("ldm_a1", memAddr, 32'h1F8);
        check_val("ldm_w1", {27'd0, rfRegW, rfAddrW}, 32'h11);
        tick();                                    // t+3
        check_val("ldm_a2", memAddr, 32'h1FC);
        check_val("ldm_w2", {27'd0, rfRegW, rfAddrW}, 32'h1F);
        check_val("ldm_d2", rfDataW, 32'hA5A5_01FC);
        tick();                                    // t+4
        check_val("ldm_done", {31'd0, done}, 32'd1);
        check_val("ldm_no_wb", {31'd0, rfRegW}, 32'd0);
        tick();

        // LDM R4,R5 with a three-cycle stall on the second transfer
        issue(1'b1, 16'h0030, 4'd2, 32'h300, 1'b0, 1'b1, 1'b0);
        tick(); start = 1'b0;                      // t+1
        check_val("stl_a0", memAddr, 32'h300);
        check_val("stl_w0", {27'd0, rfRegW, rfAddrW}, 32'h14);
        for (int k = 0; k < 3; k++) begin
            tick(); memReady = 1'b0; #1;           // t+2..t+4
            check_val("stl_hold_a", memAddr, 32'h304);
            check_val("stl_hold_rd", {31'd0, memRead}, 32'd1);
            check_val("stl_hold_we", {31'd0, rfRegW}, 32'd0);
        end
        tick(); memReady = 1'b1; #1;               // t+5
        check_val("stl_w1", {27'd0, rfRegW, rfAddrW}, 32'h15);
        check_val("stl_notdone", {31'd0, done}, 32'd0);
        tick();                                    // t+6
        check_val("stl_done", {31'd0, done}, 32'd1);
        tick();

        // Empty register list
        issue(1'b1, 16'h0000, 4'd0, 32'h400, 1'b0, 1'b1, 1'b1);
        tick(); start = 1'b0;                      // t+1
        check_val("empty_done_err", {30'd0, done, err}, 32'd3);
        check_val("empty_strobes", {29'd0, memRead, memWrite, rfRegW}, 32'd0);
        tick();
        check_val("empty_after", {29'd0, busy, done, err}, 32'd0);

        // Reset during the second transfer cycle, then a normal request
        issue(1'b0, 16'h0003, 4'd3, 32'h400, 1'b0, 1'b1, 1'b1);
        tick(); start = 1'b0;                      // t+1
        tick();                                    // t+2
        reset = 1'b0; #1;
        check_val("abort_busy", {30'd0, busy, done}, 32'd0);
        check_val("abort_addr", memAddr, 32'd0);
        check_val("abort_strobes", {29'd0, memRead, memWrite, rfRegW}, 32'd0);
        tick();
        check_val("abort_held", {28'd0, busy, memWrite, rfRegW, done}, 32'd0);
        reset = 1'b1;
        tick();
        issue(1'b0, 16'h0010, 4'd3, 32'h500, 1'b0, 1'b1, 1'b0);
        tick(); start = 1'b0;                      // t+1
        check_val("post_a0", memAddr, 32'h500);
        check_val("post_ra", {27'd0, memWrite, rfAddrA}, 32'h14);
        tick();
        check_val("post_done", {31'd0, done}, 32'd1);
        tick();

        // Address wrap with a second start ignored while busy
        issue(1'b0, 16'h0003, 4'd5, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        tick();                                    // t+1
        regList = 16'hFFFF; baseAddr = 32'h800;    // start still high while busy
        check_val("wrap_a0", memAddr, 32'hFFFF_FFFC);
        tick(); start = 1'b0;                      // t+2
        check_val("wrap_a1", memAddr, 32'h0000_0000);
        check_val("wrap_ra1", {28'd0, rfAddrA}, 32'd1);
        tick();                                    // t+3
        check_val("wrap_done", {31'd0, done}, 32'd1);
        tick();
        check_val("wrap_not_queued", {29'd0, busy, memWrite, memRead}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
